// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit receiver and the downstream prime stage.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned      BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // True when the code is a legal decimal digit.
  function automatic logic is_bcd(input logic [BCD_W-1:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_digit_rx_if.sv
// Serial input, digit output handshake and error reporting of the BCD receiver.
interface bcd_serial_digit_rx_if
  import bcd_pkg::*;
#(
  parameter int unsigned ERR_W = 8
);

  logic             ser_valid;
  logic             ser_sof;
  logic             ser_bit;
  logic             ser_ready;
  logic [BCD_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             err_code;
  logic             err_frame;
  logic             err_timeout;
  logic [ERR_W-1:0] err_cnt;

  // Upstream bit source / downstream consumer side.
  modport master (
    output ser_valid, ser_sof, ser_bit, dout_ready,
    input  ser_ready, dout, dout_valid, err_code, err_frame, err_timeout, err_cnt
  );

  // Receiver side.
  modport slave (
    input  ser_valid, ser_sof, ser_bit, dout_ready,
    output ser_ready, dout, dout_valid, err_code, err_frame, err_timeout, err_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count one per cycle with inc asserted, stopping at the maximum value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bcd_serial_digit_rx.sv
// Assembles 4-bit BCD digits from a serial stream, filters codes 10..15,
// aborts stalled frames and presents each digit under valid/ready.
module bcd_serial_digit_rx
  import bcd_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_digit_rx_if.slave  bus
);

  // Timer value at which the next idle cycle completes the timeout.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [2:0]       sr, sr_n;         // first three bits of the frame
  logic [2:0]       cnt, cnt_n;       // bits accepted so far in the frame
  logic [7:0]       timer, timer_n;   // idle cycles since last accepted bit
  logic [BCD_W-1:0] dout_q, dout_n;
  logic             dv_q, dv_n;
  logic             ec_q, ec_n;
  logic             ef_q, ef_n;
  logic             et_q, et_n;
  logic             err_any_n;
  logic             ready;
  logic             accept;
  logic [2:0]       sr_shift;
  logic [2:0]       sr_first;
  logic [BCD_W-1:0] assembled;
  logic [ERR_W-1:0] err_cnt;

  assign ready  = (state != HOLD);
  assign accept = bus.ser_valid & ready;

  // Only three bits are stored: the fourth is merged with them combinationally
  // on its arrival, so the digit is checked and registered in the same cycle.
  // A frame start is a shift into an all-zero register.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shift  = {sr[1:0], bus.ser_bit};
      sr_first  = {2'b00, bus.ser_bit};
      assembled = {sr, bus.ser_bit};
    end else begin
      sr_shift  = {bus.ser_bit, sr[2:1]};
      sr_first  = {bus.ser_bit, 2'b00};
      assembled = {bus.ser_bit, sr};
    end
  end

  // Next-state, datapath and error-pulse decisions.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    timer_n = timer;
    dout_n  = dout_q;
    dv_n    = dv_q;
    ec_n    = 1'b0;
    ef_n    = 1'b0;
    et_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && bus.ser_sof) begin
          sr_n    = sr_first;
          cnt_n   = 3'd1;
          timer_n = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          timer_n = '0;
          if (bus.ser_sof) begin
            ef_n  = 1'b1;
            sr_n  = sr_first;
            cnt_n = 3'd1;
          end else if (cnt == 3'd3) begin
            cnt_n = '0;
            sr_n  = '0;
            if (is_bcd(assembled)) begin
              dout_n  = assembled;
              dv_n    = 1'b1;
              state_n = HOLD;
            end else begin
              ec_n    = 1'b1;
              state_n = IDLE;
            end
          end else begin
            sr_n  = sr_shift;
            cnt_n = cnt + 3'd1;
          end
        end else if (timer == TMO_LAST) begin
          et_n    = 1'b1;
          sr_n    = '0;
          cnt_n   = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      HOLD: begin
        if (bus.dout_ready) begin
          dv_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign err_any_n = ec_n | ef_n | et_n;

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      timer  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ec_q   <= 1'b0;
      ef_q   <= 1'b0;
      et_q   <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      timer  <= timer_n;
      dout_q <= dout_n;
      dv_q   <= dv_n;
      ec_q   <= ec_n;
      ef_q   <= ef_n;
      et_q   <= et_n;
    end
  end

  // Counter steps on the same edge that raises the error pulse, so the
  // new count is visible alongside the pulse.
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_any_n),
    .cnt   (err_cnt)
  );

  assign bus.ser_ready   = ready;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dv_q;
  assign bus.err_code    = ec_q;
  assign bus.err_frame   = ef_q;
  assign bus.err_timeout = et_q;
  assign bus.err_cnt     = err_cnt;

endmodule

// File: tb/tb_bcd_serial_digit_rx.sv
// Scoreboard bench for bcd_serial_digit_rx: MSB-first instance (ERR_W=8) and
// LSB-first instance (ERR_W=2).
module tb_bcd_serial_digit_rx;

  localparam int K_DIG  = 0;
  localparam int K_CODE = 1;
  localparam int K_FRM  = 2;
  localparam int K_TMO  = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  ev_t qa[$];
  ev_t qb[$];

  bcd_serial_digit_rx_if #(.ERR_W(8)) bus_a ();
  bcd_serial_digit_rx_if #(.ERR_W(2)) bus_b ();

  bcd_serial_digit_rx #(
    .MSB_FIRST (1'b1),
    .TIMEOUT   (8),
    .ERR_W     (8)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  bcd_serial_digit_rx #(
    .MSB_FIRST (1'b0),
    .TIMEOUT   (8),
    .ERR_W     (2)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct comparison of a sampled value against a hand-computed one.
  function automatic void check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  // Pop the oldest expected event for one instance and compare.
  function automatic void take(input int which, input int kind, input int val, input string nm);
    ev_t e;
    n_cmp++;
    if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
      n_bad++;
      $display("FAIL %s: unexpected event kind=%0d val=%0d with nothing expected", nm, kind, val);
      return;
    end
    if (which == 0) e = qa.pop_front();
    else            e = qb.pop_front();
    if (e.kind != kind || e.val != val) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d val=%0d expected kind=%0d val=%0d",
               nm, kind, val, e.kind, e.val);
    end
  endfunction

  function automatic void expect_ev(input int which, input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endfunction

  // Monitor: every observable output event must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.dout_valid && bus_a.dout_ready) take(0, K_DIG, int'(bus_a.dout), "a_digit");
      if (bus_a.err_code)    take(0, K_CODE, int'(bus_a.err_cnt), "a_err_code");
      if (bus_a.err_frame)   take(0, K_FRM,  int'(bus_a.err_cnt), "a_err_frame");
      if (bus_a.err_timeout) take(0, K_TMO,  int'(bus_a.err_cnt), "a_err_timeout");
      if (bus_b.dout_valid && bus_b.dout_ready) take(1, K_DIG, int'(bus_b.dout), "b_digit");
      if (bus_b.err_code)    take(1, K_CODE, int'(bus_b.err_cnt), "b_err_code");
      if (bus_b.err_frame)   take(1, K_FRM,  int'(bus_b.err_cnt), "b_err_frame");
      if (bus_b.err_timeout) take(1, K_TMO,  int'(bus_b.err_cnt), "b_err_timeout");
    end
  end

  // Offer one bit; returns one cycle after it was accepted (posedge + 1).
  task automatic bit_x(input int which, input logic sof, input logic b);
    int k;
    logic rdy;
    k = 0;
    if (which == 0) begin
      bus_a.ser_valid = 1'b1; bus_a.ser_sof = sof; bus_a.ser_bit = b;
    end else begin
      bus_b.ser_valid = 1'b1; bus_b.ser_sof = sof; bus_b.ser_bit = b;
    end
    rdy = (which == 0) ? bus_a.ser_ready : bus_b.ser_ready;
    while (!rdy && k < 50) begin
      @(posedge clk); #1;
      k++;
      rdy = (which == 0) ? bus_a.ser_ready : bus_b.ser_ready;
    end
    if (k >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ser_ready_wait: got ready=0 for %0d cycles expected 1", k);
    end
    @(posedge clk); #1;
    if (which == 0) begin
      bus_a.ser_valid = 1'b0; bus_a.ser_sof = 1'b0;
    end else begin
      bus_b.ser_valid = 1'b0; bus_b.ser_sof = 1'b0;
    end
  endtask

  // Send a four-bit frame; seq[3] goes on the wire first.
  task automatic frame_x(input int which, input logic [3:0] seq);
    for (int i = 3; i >= 0; i--) bit_x(which, (i == 3), seq[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Digit just completed with dout_ready=1: one-cycle latency, one HOLD cycle.
  task automatic digit_done_a(input int v, input string nm);
    check({nm, "_valid"}, int'(bus_a.dout_valid), 1);
    check({nm, "_dout"}, int'(bus_a.dout), v);
    check({nm, "_ready_low"}, int'(bus_a.ser_ready), 0);
    idle(1);
    check({nm, "_ready_back"}, int'(bus_a.ser_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus_a.ser_valid = 1'b0; bus_a.ser_sof = 1'b0; bus_a.ser_bit = 1'b0; bus_a.dout_ready = 1'b1;
    bus_b.ser_valid = 1'b0; bus_b.ser_sof = 1'b0; bus_b.ser_bit = 1'b0; bus_b.dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_a_dout",  int'(bus_a.dout), 0);
    check("rst_a_valid", int'(bus_a.dout_valid), 0);
    check("rst_a_ready", int'(bus_a.ser_ready), 1);
    check("rst_a_errcnt", int'(bus_a.err_cnt), 0);
    check("rst_b_errcnt", int'(bus_b.err_cnt), 0);

    // Reset mid-frame discards the partial frame.
    bit_x(0, 1'b1, 1'b1);
    bit_x(0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst_dout",  int'(bus_a.dout), 0);
    check("midrst_valid", int'(bus_a.dout_valid), 0);
    check("midrst_ready", int'(bus_a.ser_ready), 1);
    expect_ev(0, K_DIG, 7);
    frame_x(0, 4'b0111);
    digit_done_a(7, "d7");

    // Back-to-back digits with the consumer always ready.
    expect_ev(0, K_DIG, 3);
    frame_x(0, 4'b0011);
    digit_done_a(3, "d3");
    expect_ev(0, K_DIG, 5);
    frame_x(0, 4'b0101);
    digit_done_a(5, "d5");
    expect_ev(0, K_DIG, 9);
    frame_x(0, 4'b1001);
    digit_done_a(9, "d9");

    // Backpressure: digit held, offered bits refused.
    bus_a.dout_ready = 1'b0;
    expect_ev(0, K_DIG, 2);
    frame_x(0, 4'b0010);
    bus_a.ser_valid = 1'b1; bus_a.ser_sof = 1'b1; bus_a.ser_bit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_ready_low", int'(bus_a.ser_ready), 0);
      check("bp_dout_hold", int'(bus_a.dout), 2);
      check("bp_valid_hold", int'(bus_a.dout_valid), 1);
      idle(1);
    end
    bus_a.ser_valid = 1'b0; bus_a.ser_sof = 1'b0;
    bus_a.dout_ready = 1'b1;
    idle(1);
    check("bp_valid_fall", int'(bus_a.dout_valid), 0);
    check("bp_dout_keep", int'(bus_a.dout), 2);
    check("bp_idle_ready", int'(bus_a.ser_ready), 1);
    idle(12);

    // Codes 10..15 are dropped and counted.
    expect_ev(0, K_CODE, 1);
    frame_x(0, 4'b1100);
    idle(2);
    check("code12_valid", int'(bus_a.dout_valid), 0);
    check("code12_dout", int'(bus_a.dout), 2);
    expect_ev(0, K_CODE, 2);
    frame_x(0, 4'b1010);
    idle(1);
    check("code10_errcnt", int'(bus_a.err_cnt), 2);

    // Sof mid-frame restarts the frame.
    expect_ev(0, K_FRM, 3);
    expect_ev(0, K_DIG, 6);
    bit_x(0, 1'b1, 1'b1);
    bit_x(0, 1'b0, 1'b0);
    bit_x(0, 1'b1, 1'b0);
    bit_x(0, 1'b0, 1'b1);
    bit_x(0, 1'b0, 1'b1);
    bit_x(0, 1'b0, 1'b0);
    digit_done_a(6, "d6");

    // Timeout after exactly TIMEOUT idle cycles.
    expect_ev(0, K_TMO, 4);
    bit_x(0, 1'b1, 1'b1);
    idle(7);
    check("tmo_early", int'(bus_a.err_timeout), 0);
    idle(1);
    check("tmo_pulse", int'(bus_a.err_timeout), 1);
    check("tmo_ready", int'(bus_a.ser_ready), 1);
    idle(3);
    check("tmo_novalid", int'(bus_a.dout_valid), 0);

    // Narrow counter saturates; LSB-first assembly.
    expect_ev(1, K_CODE, 1);
    expect_ev(1, K_CODE, 2);
    expect_ev(1, K_CODE, 3);
    expect_ev(1, K_CODE, 3);
    expect_ev(1, K_CODE, 3);
    for (int f = 0; f < 5; f++) frame_x(1, 4'b0101);
    idle(1);
    check("sat_errcnt", int'(bus_b.err_cnt), 3);
    expect_ev(1, K_DIG, 7);
    frame_x(1, 4'b1110);
    check("lsb_valid", int'(bus_b.dout_valid), 1);
    check("lsb_dout", int'(bus_b.dout), 7);

    idle(5);
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_digit_rx.md
Name: bcd_serial_digit_rx

Overview:
Serial-to-parallel receiver that assembles 4-bit BCD digits from a one-bit stream and presents each digit, registered, to the downstream prime-detect stage.
- Codes 10..15 are filtered out and flagged here. The prime stage treats them as don't-care and must never see them.
- Output digits are held under a valid/ready handshake.
- Stalled frames are aborted by a timeout.

Parameters:
- MSB_FIRST, 1, 1 = first bit of a frame is digit bit 3; 0 = first bit is digit bit 0.
- TIMEOUT, 8, max idle cycles allowed between bits inside a frame. Range 1..255.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- ser_valid  in  1  ser_bit/ser_sof are valid this cycle.
- ser_sof  in  1  marks the first bit of a 4-bit frame.
- ser_bit  in  1  serial data bit.
- ser_ready  out  1  receiver can accept a bit. Equals (state != HOLD).
- dout  out  4  assembled BCD digit, to prime stage input.
- dout_valid  out  1  dout holds a valid digit 0..9.
- dout_ready  in  1  consumer accepts dout. Tie high for a purely combinational consumer.
- err_code  out  1  one-cycle pulse: frame decoded to 10..15.
- err_frame  out  1  one-cycle pulse: sof arrived mid-frame.
- err_timeout  out  1  one-cycle pulse: frame aborted on timeout.
- err_cnt  out  ERR_W  saturating count of all error events.

Behaviour:
Reset (rst_n=0 at a clk edge, any state, including mid-frame or HOLD):
- state=IDLE; shift reg, bit count and idle timer cleared.
- dout=0, dout_valid=0, all err pulses 0, err_cnt=0.
- A partial frame is discarded.

A bit is accepted on a cycle with ser_valid & ser_ready.

FSM states: IDLE, SHIFT, HOLD.

IDLE:
- Accepted bit with ser_sof=1 → store bit, cnt=1, timer=0, go SHIFT.
- Accepted bit with ser_sof=0 → ignored, no error.

SHIFT:
- Accepted bit with ser_sof=0 → shift in per MSB_FIRST, cnt++, timer=0.
- Accepted bit with ser_sof=1 → err_frame pulse, restart frame with this bit as bit 1 (cnt=1).
- No accepted bit → timer++. When timer reaches TIMEOUT → err_timeout pulse, go IDLE.
- On the cycle the 4th bit is accepted, the assembled value v is checked:
  - v <= 9 → next cycle dout=v, dout_valid=1, go HOLD.
  - v >= 10 → next cycle err_code pulse, go IDLE; dout and dout_valid unchanged (dout_valid stays 0).
- Latency: dout_valid rises exactly 1 cycle after the 4th bit is accepted.

HOLD:
- ser_ready=0; incoming bits are not accepted (upstream must hold them).
- dout and dout_valid stable until dout_ready=1.
- On dout_valid & dout_ready → dout_valid=0 next cycle, go IDLE. dout retains its last value.
- A new sof can be accepted no earlier than the cycle after the handshake.
- No timeout runs in HOLD.

err_cnt:
- Increments by 1 for each cycle with any err pulse asserted.
- At most one error event can occur per cycle.
- Saturates at 2^ERR_W-1, with no wrap.

Timer rules:
- Width is 8 bits.
- The timer only runs in SHIFT and clears on every accepted bit.

Simultaneous events:
- An sof that also completes a frame cannot occur, since sof restarts the count.
- Reset has priority over everything.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, HOLD}
  - BCD_W=4
  - BCD_MAX=4'd9
  - function is_bcd(v) returning v <= BCD_MAX
  The downstream prime stage reuses BCD_W and BCD_MAX.
- No sub-module required. The saturating counter is optionally a small module sat_counter (params W) shared with other error counters in the design.

Test Plan:
- Reset mid-frame: send sof+1, 0 (MSB_FIRST=1), then rst_n=0 for 1 cycle → dout=0, dout_valid=0, ser_ready=1. A fresh frame 0,1,1,1 → dout=4'd7, dout_valid=1 on the cycle after the 4th bit.
- Back-to-back digits, dout_ready=1: frames 0011, 0101, 1001 → dout 3, 5, 9 each valid for 1 cycle. ser_ready low for exactly 1 cycle after each frame.
- Backpressure: frame 0010 with dout_ready=0 for 5 cycles → dout=2 held and ser_ready=0 for the whole window; bits offered during HOLD are not consumed. dout_ready=1 → dout_valid falls next cycle.
- Invalid code: frame 1100 (12) → err_code pulse 1 cycle, dout_valid stays 0, err_cnt=1. Frame 1010 (10) → err_cnt=2.
- Mid-frame sof: sof+1, 0, then sof+0, 1, 1, 0 → err_frame pulse on the second sof, then dout=4'd6. Timeout: sof+1, then 8 idle cycles with TIMEOUT=8 → err_timeout pulse, state IDLE, no dout_valid.
- Saturation with ERR_W=2: 5 invalid frames → err_cnt sequence 1, 2, 3, 3, 3. MSB_FIRST=0 run: bits 1, 1, 1, 0 → dout=4'd7.
